// File: rtl/pipe_mult_shift_add.sv
// Pipelined unsigned WIDTH x WIDTH multiplier: one shift-add stage per multiplier bit,
// each stage folding one masked partial product into the running sum with a ripple adder.
module pipe_mult_shift_add #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] SLICE_MASK = {{(PW-WIDTH-1){1'b0}}, {(WIDTH+1){1'b1}}};

    function automatic logic [WIDTH:0] rippleAdd(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] s;
        logic             c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // The last stage only needs v, p and tag; its a and b would never be read.
    logic [WIDTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] a_q   [WIDTH-1];
    logic [WIDTH-1:0] a_d   [WIDTH-1];
    logic [WIDTH-1:0] b_q   [WIDTH-1];
    logic [WIDTH-1:0] b_d   [WIDTH-1];
    logic [TAG_W-1:0] tag_q [WIDTH];
    logic [TAG_W-1:0] tag_d [WIDTH];
    logic [PW-1:0]    p_q   [WIDTH];
    logic [PW-1:0]    p_d   [WIDTH];
    logic [PW-1:0]    pLoad [WIDTH];
    logic             stall;

    assign stall    = vld_q[WIDTH-1] & ~out_ready;
    assign in_ready = ~stall;

    assign pLoad[0] = {{WIDTH{1'b0}}, in_a & {WIDTH{in_b[0]}}};

    // Stage k replaces bits [k+WIDTH:k] of the running sum with slice + partial product.
    for (genvar k = 1; k < WIDTH; k++) begin : gStage
        logic [WIDTH:0] sum;
        assign sum      = rippleAdd(p_q[k-1][k +: WIDTH], a_q[k-1] & {WIDTH{b_q[k-1][k]}});
        assign pLoad[k] = (p_q[k-1] & ~(SLICE_MASK << k)) | (PW'(sum) << k);
    end

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        tag_d = tag_q;
        p_d   = p_q;
        if (!stall) begin
            vld_d    = {vld_q[WIDTH-2:0], in_valid & in_ready};
            a_d[0]   = in_a;
            b_d[0]   = in_b;
            tag_d[0] = in_tag;
            p_d[0]   = pLoad[0];
            for (int k = 1; k < WIDTH - 1; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
            end
            for (int k = 1; k < WIDTH; k++) begin
                tag_d[k] = tag_q[k-1];
                p_d[k]   = pLoad[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            tag_q <= '{default: '0};
            p_q   <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_d;
            p_q   <= p_d;
        end
    end

    assign out_valid   = vld_q[WIDTH-1];
    assign out_product = p_q[WIDTH-1];
    assign out_tag     = tag_q[WIDTH-1];
    assign busy        = |vld_q;

endmodule

// File: tb/tb_pipe_mult_shift_add.sv
// Bench for pipe_mult_shift_add: a delay-line reference model checked every cycle,
// plus directed scenarios with hand-computed products, tags and timing.
module tb_pipe_mult_shift_add;

    localparam int W  = 4;
    localparam int TW = 2;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_product;
    logic [TW-1:0] out_tag;
    logic          busy;

    pipe_mult_shift_add #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] prod;
        logic [TW-1:0] tag;
        int            cyc;
    } logEntry_t;

    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    bit        checkEn = 0;
    logEntry_t logQ[$];

    // Reference: a WIDTH-deep delay line of (valid, a*b, tag) that freezes while the head is stalled.
    bit            mV [W];
    logic [PW-1:0] mP [W];
    logic [TW-1:0] mT [W];
    wire           mStall = mV[W-1] && !out_ready;
    wire           anyV   = mV[0] | mV[1] | mV[2] | mV[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                mV[i] <= 1'b0;
                mP[i] <= '0;
                mT[i] <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            if (!mStall) begin
                for (int i = 1; i < W; i++) begin
                    mV[i] <= mV[i-1];
                    mP[i] <= mP[i-1];
                    mT[i] <= mT[i-1];
                end
                mV[0] <= in_valid;
                mP[0] <= PW'(in_a) * PW'(in_b);
                mT[0] <= in_tag;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && checkEn) begin
            checkOutput("out_valid", out_valid, mV[W-1]);
            if (mV[W-1]) begin
                checkOutput("out_product", out_product, mP[W-1]);
                checkOutput("out_tag", out_tag, mT[W-1]);
            end
            checkOutput("in_ready", in_ready, !mStall);
            checkOutput("busy", busy, anyV);
            if (out_valid && out_ready)
                logQ.push_back('{out_product, out_tag, cyc});
        end
    end

    function automatic logic [31:0] logProd(input int i);
        return (i < logQ.size()) ? 32'(logQ[i].prod) : 32'hFFFF;
    endfunction

    function automatic logic [31:0] logTag(input int i);
        return (i < logQ.size()) ? 32'(logQ[i].tag) : 32'hFFFF;
    endfunction

    function automatic logic [31:0] logCyc(input int i);
        return (i < logQ.size()) ? 32'(logQ[i].cyc) : 32'hFFFF;
    endfunction

    // One cycle: drive inputs after an edge, sample handshake at the falling edge, step to next edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag, input logic ordy,
                                 output logic acc, output logic irdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        @(negedge clk);
        irdy = in_ready;
        acc  = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        logic acc, irdy;
        applyStimulus(1'b0, '0, '0, '0, ordy, acc, irdy);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((busy === 1'b1 || anyV) && n < budget) begin
            idle(1'b1);
            n++;
        end
        checkOutput("drain_done", busy, 0);
    endtask

    initial begin
        logic acc, irdy;
        logic [W-1:0] za [5] = '{4'd0, 4'd9, 4'd1, 4'd13, 4'd8};
        logic [W-1:0] zb [5] = '{4'd9, 4'd0, 4'd13, 4'd1, 4'd8};
        int           zp [5] = '{0, 0, 13, 13, 64};
        bit           bubV [6] = '{1, 0, 1, 0, 0, 1};
        logic [W-1:0] bubB [6] = '{4'd5, 4'd0, 4'd7, 4'd0, 4'd0, 4'd11};
        int           bpP [6] = '{18, 30, 44, 60, 78, 98};
        int           idx, n, stallLeft, irLow;
        bit           seen;
        logic         ordy;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_product", out_product, 0);
        checkOutput("rst_out_tag", out_tag, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkEn = 1;

        // Basic product with exact latency
        logQ.delete();
        applyStimulus(1'b1, 4'd15, 4'd15, 2'd2, 1'b1, acc, irdy);
        checkOutput("basic_accept", acc, 1);
        for (int i = 1; i <= 3; i++) begin
            idle(1'b1);
            checkOutput("basic_valid_edge", out_valid, (i == 3) ? 1 : 0);
        end
        checkOutput("basic_product", out_product, 225);
        checkOutput("basic_tag", out_tag, 2);
        idle(1'b1);
        checkOutput("basic_valid_after", out_valid, 0);
        drain(20);

        // Zero and identity operands back to back
        logQ.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, za[i], zb[i], 2'(i), 1'b1, acc, irdy);
            checkOutput("zero_accept", acc, 1);
        end
        checkOutput("zero_busy", busy, 1);
        drain(20);
        checkOutput("zero_count", logQ.size(), 5);
        for (int i = 0; i < 5; i++)
            checkOutput("zero_product", logProd(i), zp[i]);
        checkOutput("zero_consecutive", logCyc(4) - logCyc(0), 4);

        // Exhaustive at full throughput
        logQ.delete();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 4'(i >> 4), 4'(i), 2'(i), 1'b1, acc, irdy);
            checkOutput("exh_accept", acc, 1);
        end
        drain(20);
        checkOutput("exh_count", logQ.size(), 256);
        checkOutput("exh_rate", logCyc(255) - logCyc(0), 255);
        checkOutput("exh_p255", logProd(255), 225);
        checkOutput("exh_t255", logTag(255), 3);
        checkOutput("exh_p37", logProd(8'h37), 21);
        checkOutput("exh_t37", logTag(8'h37), 3);
        checkOutput("exh_pA5", logProd(8'hA5), 50);
        checkOutput("exh_tA5", logTag(8'hA5), 1);

        // Backpressure: five-cycle stall once the first result shows
        logQ.delete();
        idx = 0; n = 0; stallLeft = 5; irLow = 0; seen = 0;
        while ((idx < 6 || logQ.size() < 6) && n < 80) begin
            if (out_valid) seen = 1;
            ordy = !(seen && stallLeft > 0);
            if (!ordy) stallLeft--;
            if (idx < 6)
                applyStimulus(1'b1, 4'(idx + 2), 4'(idx + 9), 2'(idx), ordy, acc, irdy);
            else
                applyStimulus(1'b0, '0, '0, '0, ordy, acc, irdy);
            if (!irdy) irLow++;
            if (acc) idx++;
            n++;
        end
        checkOutput("bp_count", logQ.size(), 6);
        checkOutput("bp_inready_low", irLow, 5);
        for (int i = 0; i < 6; i++) begin
            checkOutput("bp_product", logProd(i), bpP[i]);
            checkOutput("bp_tag", logTag(i), i % 4);
        end
        drain(20);

        // Bubbles
        logQ.delete();
        for (int i = 0; i < 6; i++)
            applyStimulus(bubV[i], 4'd3, bubB[i], 2'(i), 1'b1, acc, irdy);
        drain(20);
        checkOutput("bub_count", logQ.size(), 3);
        checkOutput("bub_p0", logProd(0), 15);
        checkOutput("bub_p1", logProd(1), 21);
        checkOutput("bub_p2", logProd(2), 33);
        checkOutput("bub_gap1", logCyc(1) - logCyc(0), 2);
        checkOutput("bub_gap2", logCyc(2) - logCyc(1), 3);

        // Asynchronous reset with entries in flight
        logQ.delete();
        applyStimulus(1'b1, 4'd7, 4'd9, 2'd1, 1'b1, acc, irdy);
        applyStimulus(1'b1, 4'd5, 4'd6, 2'd2, 1'b1, acc, irdy);
        applyStimulus(1'b1, 4'd3, 4'd3, 2'd3, 1'b1, acc, irdy);
        idle(1'b0);
        checkOutput("mid_valid_pre", out_valid, 1);
        checkOutput("mid_product_pre", out_product, 63);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_out_valid", out_valid, 0);
        checkOutput("mid_out_product", out_product, 0);
        checkOutput("mid_out_tag", out_tag, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (8) idle(1'b1);
        checkOutput("mid_no_stale", logQ.size(), 0);
        checkOutput("mid_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
